// File: rtl/multi_wave_pkg.sv
// Shared mode codes and FSM state type for the multi-mode waveform generator.
package multi_wave_pkg;

   localparam logic [1:0] MODE_SINE   = 2'd0;
   localparam logic [1:0] MODE_SQUARE = 2'd1;
   localparam logic [1:0] MODE_TRI    = 2'd2;
   localparam logic [1:0] MODE_SAW    = 2'd3;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_e;

endpackage

// File: rtl/multi_wave_gen_if.sv
// Control and sample bus between a waveform consumer (master) and the generator (slave).
interface multi_wave_gen_if #(
   parameter int OUT_W = 8,
   parameter int DIV_W = 8
) ();

   logic             en;
   logic [1:0]       mode;
   logic [DIV_W-1:0] div;
   logic [OUT_W-1:0] wave;
   logic             sample_valid;
   logic             period_wrap;
   logic [1:0]       mode_active;

   modport master (
      output en, mode, div,
      input  wave, sample_valid, period_wrap, mode_active
   );

   modport slave (
      input  en, mode, div,
      output wave, sample_valid, period_wrap, mode_active
   );

endinterface

// File: rtl/wave_tick_div.sv
// Step-rate divider: one tick every div+1 enabled clocks; count freezes while en=0.
module wave_tick_div #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

   // >= rather than == so that lowering div mid-count fires on the very next clock.
   always_comb begin
      // NOTE: every comb output gets a default first so no latch is inferred.
      tick      = en && (div_cnt_q >= div);
      div_cnt_d = div_cnt_q;
      if (tick) begin
         div_cnt_d = '0;
      end else if (en) begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/multi_wave_gen.sv
// Sine (Minsky recurrence) / square / triangle / sawtooth source with glitch-free,
// period-aligned mode switching and a registered offset-binary output.
module multi_wave_gen
   import multi_wave_pkg::*;
#(
   parameter int OUT_W    = 8,
   parameter int ACC_W    = 16,
   parameter int SHIFT    = 6,
   parameter int COS_INIT = 30000,
   parameter int PH_W     = 9,
   parameter int DIV_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multi_wave_gen_if.slave      bus
);

   localparam logic [OUT_W-1:0]        OFFSET   = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] COS_SEED = ACC_W'(COS_INIT);

   logic                    tick;
   logic signed [ACC_W-1:0] sin_q, sin_d, cos_q, cos_d;
   logic signed [ACC_W-1:0] sin_n, cos_n;
   logic [PH_W-1:0]         phase_q, phase_d, phase_n;
   logic [1:0]              mode_active_q, mode_active_d;
   state_e                  state_q, state_d;
   logic [OUT_W-1:0]        wave_q, wave_d, sample_n;
   logic                    sample_valid_q, sample_valid_d;
   logic                    period_wrap_q, period_wrap_d;
   logic                    wrap, do_switch;
   logic [PH_W-2:0]         tri_t, tri_f;

   wave_tick_div #(.DIV_W(DIV_W)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.en),
      .div   (bus.div),
      .tick  (tick)
   );

   // Cos update must use the freshly updated sin, otherwise the amplitude drifts.
   always_comb begin
      sin_n   = sin_q + (cos_q >>> SHIFT);
      cos_n   = cos_q - (sin_n >>> SHIFT);
      phase_n = phase_q + 1'b1;
      if (mode_active_q == MODE_SINE) begin
         wrap = sin_q[ACC_W-1] & ~sin_n[ACC_W-1];
      end else begin
         wrap = (phase_q == '1);
      end
   end

   always_comb begin
      tri_t = phase_n[PH_W-2:0];
      tri_f = phase_n[PH_W-1] ? ~tri_t : tri_t;
      case (mode_active_q)
         MODE_SINE:   sample_n = sin_n[ACC_W-1 -: OUT_W] + OFFSET;
         MODE_SQUARE: sample_n = phase_n[PH_W-1] ? {OUT_W{1'b1}} : '0;
         MODE_TRI:    sample_n = tri_f[PH_W-2 -: OUT_W];
         default:     sample_n = phase_n[PH_W-1 -: OUT_W];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (bus.mode != mode_active_q) state_d = ST_PEND;
         end
         default: begin
            if (bus.mode == mode_active_q || !bus.en || (tick && wrap)) state_d = ST_RUN;
         end
      endcase
   end

   // The wrap tick still renders the old mode; reseeding only affects the following steps.
   always_comb begin
      do_switch      = (state_q == ST_PEND) && (bus.mode != mode_active_q) &&
                       (!bus.en || (tick && wrap));
      sin_d          = sin_q;
      cos_d          = cos_q;
      phase_d        = phase_q;
      mode_active_d  = mode_active_q;
      wave_d         = wave_q;
      sample_valid_d = 1'b0;
      period_wrap_d  = 1'b0;
      if (tick) begin
         sin_d          = sin_n;
         cos_d          = cos_n;
         phase_d        = phase_n;
         wave_d         = sample_n;
         sample_valid_d = 1'b1;
         period_wrap_d  = wrap;
      end
      if (do_switch) begin
         sin_d         = '0;
         cos_d         = COS_SEED;
         phase_d       = '0;
         mode_active_d = bus.mode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sin_q          <= '0;
         cos_q          <= COS_SEED;
         phase_q        <= '0;
         mode_active_q  <= MODE_SINE;
         wave_q         <= OFFSET;
         sample_valid_q <= 1'b0;
         period_wrap_q  <= 1'b0;
      end else begin
         sin_q          <= sin_d;
         cos_q          <= cos_d;
         phase_q        <= phase_d;
         mode_active_q  <= mode_active_d;
         wave_q         <= wave_d;
         sample_valid_q <= sample_valid_d;
         period_wrap_q  <= period_wrap_d;
      end
   end

   assign bus.wave         = wave_q;
   assign bus.sample_valid = sample_valid_q;
   assign bus.period_wrap  = period_wrap_q;
   assign bus.mode_active  = mode_active_q;

endmodule
